// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial add/subtract sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

    localparam int SA_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for serial_add_ctrl; master issues operands, slave returns results.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) ();

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, overflow
    );

endinterface

// File: rtl/serial_add_ctrl_fulladder.sv
// Single-bit full adder cell, reused every cycle by the serial sequencer.
module fulladder (
    input  logic ain,
    input  logic bin,
    input  logic cin,
    output logic cout,
    output logic sout
);

    assign sout = ain ^ bin ^ cin;
    assign cout = (ain & bin) | (cin & (ain ^ bin));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one fulladder, LSB first, WIDTH cycles per result.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_ctrl_if.slave    bus
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    sa_state_t        state, nstate;
    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_cat;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic             fa_cout;
    logic             fa_sout;
    logic             last;
    logic             accept;

    fulladder u_fa (
        .ain  (sa[0]),
        .bin  (sb[0]),
        .cin  (carry),
        .cout (fa_cout),
        .sout (fa_sout)
    );

    assign last    = (cnt == LAST);
    assign accept  = bus.start && (state == IDLE || state == DONE);
    // Incoming sum bit lands on top; on the final cycle this is the whole result.
    assign res_cat = {fa_sout, res};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (bus.start) nstate = RUN;
            RUN:     if (last)      nstate = DONE;
            DONE:    nstate = bus.start ? RUN : IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            // Subtract as a + ~b + 1: invert B here, seed the carry with sub.
            sa    <= bus.a;
            sb    <= bus.b ^ {WIDTH{bus.sub}};
            carry <= bus.sub;
            cnt   <= '0;
            res   <= '0;
            sum_q <= '0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            carry <= fa_cout;
            res   <= res_cat[WIDTH-1:1];
            if (!last) cnt <= cnt + 1'b1;
            if (last) begin
                sum_q  <= res_cat;
                cout_q <= fa_cout;
                ovf_q  <= carry ^ fa_cout;
            end
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract sequencer that shares a single `fulladder` cell across all bit positions of a WIDTH-bit operation. It accepts a pair of operands on a start strobe and feeds one bit pair per clock through the adder, LSB first. It holds the running carry in a register and reports the sum, carry-out and signed overflow with a one-cycle done pulse. It is the area-minimal arithmetic path for the lab datapath, trading WIDTH cycles of latency for one adder cell.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE or DONE.
- `sub`  in  1  0 = a+b, 1 = a−b; sampled with `start`.
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse in the DONE state.
- `sum`  out  WIDTH  result; held stable from DONE until the next accepted start.
- `cout`  out  1  carry out of the MSB. For subtract, 1 = no borrow.
- `overflow`  out  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - If `start` is high, the block latches `a` into shift register A and `b ^ {WIDTH{sub}}` into shift register B.
  - It sets the carry register to `sub`, clears the bit counter to 0, clears `sum`, and goes to RUN.
  - Otherwise it stays in IDLE.
- **RUN** (each cycle)
  - The adder inputs are `ain` = A[0], `bin` = B[0] and `cin` = the carry register.
  - `sout` shifts into the result register MSB-side; the result register shifts right by one.
  - A and B shift right by one, the carry register takes `cout`, and the counter increments.
  - On the cycle where the counter equals WIDTH−1, the block records the adder's `cin` as `msb_cin`.
  - It then updates `sum`, `cout` and `overflow = msb_cin ^ adder cout`, and goes to DONE.
- **DONE**
  - `done` = 1 for exactly this cycle.
  - If `start` is high, the block latches new operands exactly as in IDLE and goes straight to RUN (back-to-back operation).
  - Otherwise it goes to IDLE.
- `start` in RUN is ignored: there is no queueing and no error flag.
- Arithmetic is modulo 2^WIDTH. `cout` and `overflow` are both valid for add and subtract.
- Counter width is `$clog2(WIDTH)`. The counter never wraps in normal use, because the transition out of RUN is decoded at WIDTH−1.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `sum` 0, `cout` 0, `overflow` 0, and all shift, carry and counter registers 0.
- Reset asserted mid-RUN or in DONE aborts the operation. On the next edge all of the reset values above apply, and no `done` pulse is produced.
- If `start` is high in the same cycle as `rst`, reset wins and `start` is lost.
- Latency, with `start` accepted at edge 0:
  - `busy` is high on cycles 1..WIDTH.
  - `done` is high on cycle WIDTH+1.
  - `sum`, `cout` and `overflow` are valid from cycle WIDTH+1.
- Throughput: one result every WIDTH+1 cycles when `start` is held or re-asserted in DONE.
- `busy` and `done` are never high together.
- Outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package `serial_add_pkg`: `typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;` and a localparam for the default WIDTH.
- Natural sub-module: one instance of the existing `fulladder` (ports `ain`, `bin`, `cin`, `cout`, `sout`). All sequencing, shift registers and flags live in `serial_add_ctrl`.

## Test plan
All scenarios use WIDTH=8.
- **Add, no carry:** a=0x35, b=0x4A, sub=0 → `busy` high for 8 cycles, `done` at cycle 9, sum=0x7F, cout=0, overflow=0.
- **Wrap-around:** a=0xFF, b=0x01, sub=0 → sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01 → sum=0x80, cout=0, overflow=1.
- **Subtract with borrow:** a=0x10, b=0x20, sub=1 → sum=0xF0, cout=0, overflow=0. Then a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, overflow=1.
- **Start while busy ignored:** pulse `start` with new operands at cycle 4 of RUN → the original result arrives at cycle 9 unchanged, and the block then returns to IDLE.
- **Back-to-back:** hold `start` high with 0x01+0x02, then 0x03+0x04 presented in the DONE cycle → `done` at cycles 9 and 18, sums 0x03 then 0x07.
- **Reset mid-operation:** assert `rst` at cycle 5 of RUN → next cycle state IDLE, `busy` 0, sum 0, and no `done` pulse. A fresh start then produces a correct result.
